// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared definitions for the iterative shifter: shift-mode
//               encodings (also used by the ALU control decoder), FSM state
//               encoding, default widths and a mode-validity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

  // Default geometry: WIDTH must be a power of two, SHW = log2(WIDTH).
  localparam int WIDTH_DEF = 16;
  localparam int SHW_DEF   = 4;

  // Shift-mode encodings produced by the ALU control decoder.
  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
  // Internal marker for a captured invalid mode (11, x or z at capture).
  localparam logic [1:0] MODE_INV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // True only for the three defined encodings; x/z never match a case item,
  // so they fall into the default branch and read as invalid.
  function automatic logic is_valid_mode(input logic [1:0] m);
    logic v;
    case (m)
      MODE_SLL, MODE_SRA, MODE_ROR: v = 1'b1;
      default:                      v = 1'b0;
    endcase
    return v;
  endfunction

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_stage
// Description : One binary-weighted stage of the log shifter (combinational).
//               Shifts the operand by 2^idx according to mode when en=1,
//               otherwise passes the operand through unchanged.
// Ports       : operand [WIDTH] in  - value to shift
//               mode    [2]     in  - SLL / SRA / ROR (anything else: pass)
//               en      [1]     in  - stage enable (shamt bit for this stage)
//               idx     [KW]    in  - stage index, shift distance = 2^idx
//               shifted [WIDTH] out - stage result
// Revision    : 1.0 - initial release
// ============================================================================
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF,
  parameter int KW    = (SHW > 1) ? $clog2(SHW) : 1
) (
  input  logic [WIDTH-1:0] operand,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic [KW-1:0]    idx,
  output logic [WIDTH-1:0] shifted
);

  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] rot;

  always_comb begin
    amt = SHW'(1) << idx;
    // Rotate right: shift a doubled copy so LSB bits re-enter at the MSB.
    rot = WIDTH'({operand, operand} >> amt);

    shifted = operand;
    if (en) begin
      case (mode)
        MODE_SLL: shifted = operand << amt;
        MODE_SRA: shifted = $signed(operand) >>> amt;
        MODE_ROR: shifted = rot;
        default:  shifted = operand;
      endcase
    end
  end

endmodule : shift_stage
`default_nettype wire

// File: rtl/iter_shifter.sv
`default_nettype none
// ============================================================================
// Module      : iter_shifter
// Description : Multi-cycle log-stage shifter. One binary-weighted stage
//               (1, 2, 4, 8, ...) is applied per clock, giving a fixed latency
//               independent of the shift amount. start/busy/done handshake.
// Ports       : clk      in  - clock, rising edge
//               rst_n    in  - asynchronous active-low reset
//               start    in  - request; sampled when IDLE or DONE
//               mode     in  - 00=SLL, 01=SRA, 10=ROR, 11/x/z=invalid
//               data_in  in  - operand
//               shamt    in  - shift amount 0..WIDTH-1
//               busy     out - shift in progress
//               done     out - one-cycle result-valid pulse
//               result   out - shifted value, held until next done
//               mode_err out - captured mode was invalid (held to next start)
// Revision    : 1.0 - initial release
// ============================================================================
module iter_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mode_err
);

  localparam int KW = (SHW > 1) ? $clog2(SHW) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(SHW - 1);

  state_t           state_q,    state_d;
  logic [KW-1:0]    k_q,        k_d;
  logic [WIDTH-1:0] work_q,     work_d;
  logic [SHW-1:0]   shamt_q,    shamt_d;
  logic [1:0]       mode_q,     mode_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             mode_err_q, mode_err_d;

  logic             ready;
  logic             stage_en;
  logic [WIDTH-1:0] stage_out;

  // An invalid mode disables every stage, so the operand passes through with
  // the normal latency.
  assign stage_en = shamt_q[k_q] && (mode_q != MODE_INV);

  shift_stage #(
    .WIDTH (WIDTH),
    .SHW   (SHW),
    .KW    (KW)
  ) u_stage (
    .operand (work_q),
    .mode    (mode_q),
    .en      (stage_en),
    .idx     (k_q),
    .shifted (stage_out)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    work_d     = work_q;
    shamt_d    = shamt_q;
    mode_d     = mode_q;
    result_d   = result_q;
    mode_err_d = mode_err_q;

    ready = (state_q == IDLE) || (state_q == DONE);

    if (ready && start) begin
      work_d     = data_in;
      shamt_d    = shamt;
      // Store a clean marker so x/z on the mode bus never propagates.
      mode_d     = is_valid_mode(mode) ? mode : MODE_INV;
      k_d        = '0;
      mode_err_d = 1'b0;
      state_d    = SHIFT;
    end else begin
      case (state_q)
        SHIFT: begin
          work_d = stage_out;
          k_d    = k_q + 1'b1;
          if (k_q == K_LAST) begin
            // Result and error flag are published together on entry to DONE.
            result_d   = stage_out;
            mode_err_d = (mode_q == MODE_INV);
            state_d    = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      work_q     <= '0;
      shamt_q    <= '0;
      mode_q     <= MODE_SLL;
      result_q   <= '0;
      mode_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      work_q     <= work_d;
      shamt_q    <= shamt_d;
      mode_q     <= mode_d;
      result_q   <= result_d;
      mode_err_q <= mode_err_d;
    end
  end

  // Decoded straight from the state register so reset clears them at once;
  // being distinct states, busy and done can never overlap.
  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign mode_err = mode_err_q;

endmodule : iter_shifter
`default_nettype wire
